fsm_task_sequencer: RTL

Parametrised three-segment task-control state machine; the generalised successor to the team's fixed IDLE/WORK/DONE control pattern. Accepts a start request with a job length, issues one handshaked step per work beat, counts beats to completion, and holds DONE for a configurable number of cycles. Adds abort, a no-progress watchdog with an ERR state, and a zero-length fast path. Sits between a command source and any datapath that consumes one beat per `step_valid_o & step_ready_i`.

---
 rtl/fsm_task_sequencer_if.sv | 25 ++
 rtl/fsm_task_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fsm_task_sequencer_if.sv
// Command/step handshake bundle for fsm_task_sequencer.
// The master side drives commands and step_ready; the slave side is the sequencer.
interface fsm_task_sequencer_if #(parameter int CNT_W = 16);
  logic             start_i;
  logic [CNT_W-1:0] len_i;
  logic             abort_i;
  logic             err_clr_i;
  logic             step_ready_i;
  logic             step_valid_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [CNT_W-1:0] cnt_o;
  logic [3:0]       state_o;

  modport master (
    output start_i, len_i, abort_i, err_clr_i, step_ready_i,
    input  step_valid_o, busy_o, done_o, err_o, cnt_o, state_o
  );

  modport slave (
    input  start_i, len_i, abort_i, err_clr_i, step_ready_i,
    output step_valid_o, busy_o, done_o, err_o, cnt_o, state_o
  );
endinterface

// File: rtl/fsm_task_sequencer.sv
// IDLE/WORK/DONE/ERR task sequencer: one handshaked step per beat, watchdog,
// abort and zero-length fast path. Outputs are registered from the next state.
module fsm_task_sequencer #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1024,
  parameter int DONE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  fsm_task_sequencer_if.slave io
);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int DW_W = $clog2(DONE_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DONE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'h1,
    S_WORK = 4'h2,
    S_DONE = 4'h4,
    S_ERR  = 4'h8
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [DW_W-1:0]  dw_q, dw_d;
  logic             step_valid_q, step_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [3:0]       state_o_q, state_o_d;
  logic             beat;

  assign beat = step_valid_q & io.step_ready_i;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    dw_d    = dw_q;
    case (state_q)
      S_IDLE: begin
        if (io.start_i) begin
          cnt_d = '0;
          wd_d  = '0;
          dw_d  = '0;
          if (io.len_i != '0) begin
            state_d = S_WORK;
            len_d   = io.len_i;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WORK: begin
        // Abort wins over a simultaneous beat; that beat is not counted.
        if (io.abort_i) begin
          state_d = S_ERR;
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          wd_d  = '0;
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d = S_DONE;
            dw_d    = '0;
          end
        end else if (TIMEOUT != 0) begin
          if (wd_q == WD_LAST) state_d = S_ERR;
          else                 wd_d    = wd_q + WD_W'(1);
        end
      end
      S_DONE: begin
        if (dw_q == DW_LAST) begin
          state_d = S_IDLE;
          dw_d    = '0;
        end else begin
          dw_d = dw_q + DW_W'(1);
        end
      end
      S_ERR: begin
        if (io.err_clr_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    step_valid_d = (state_d == S_WORK);
    busy_d       = (state_d == S_WORK) || (state_d == S_DONE);
    done_d       = (state_d == S_DONE) && (state_q != S_DONE);
    err_d        = (state_d == S_ERR);
    state_o_d    = state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      wd_q         <= '0;
      dw_q         <= '0;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      state_o_q    <= 4'h1;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      dw_q         <= dw_d;
      step_valid_q <= step_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      state_o_q    <= state_o_d;
    end
  end

  assign io.step_valid_o = step_valid_q;
  assign io.busy_o       = busy_q;
  assign io.done_o       = done_q;
  assign io.err_o        = err_q;
  assign io.cnt_o        = cnt_q;
  assign io.state_o      = state_o_q;
endmodule
